usbf_dma_arb: RTL and testbench

Round-robin arbiter that shares the single external DMA channel between the per-endpoint register files' dma_req/dma_ack pairs. It grants one endpoint at a time and forwards the channel acknowledge only to the granted endpoint. It bounds each grant to a configurable burst of acks, then enforces a hold-off so the endpoint's request can settle before re-arbitration. It sits between the endpoint register-file array and the DMA channel interface, in the wishbone clock domain.

---
 rtl/usbf_dma_arb_pkg.sv | 13 +
 rtl/usbf_dma_arb_if.sv | 31 +++
 rtl/usbf_rr_pick.sv | 35 +++
 rtl/usbf_dma_arb.sv | 128 ++++++++++++
 tb/tb_usbf_dma_arb.sv | 261 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/usbf_dma_arb_pkg.sv
// Shared types and widths for the endpoint DMA arbiter and its round-robin picker.
package usbf_dma_arb_pkg;

  localparam int EP_IDX_W = 4;
  localparam int BEAT_W   = 5;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACTIVE  = 2'd1,
    HOLDOFF = 2'd2
  } arb_state_e;

endpackage

// File: rtl/usbf_dma_arb_if.sv
// Endpoint request/ack lines plus the shared DMA channel handshake.
interface usbf_dma_arb_if
  import usbf_dma_arb_pkg::*;
#(
  parameter int NUM_EP = 16
);

  logic [NUM_EP-1:0]   ep_dma_req;
  logic [NUM_EP-1:0]   ep_dma_ack;
  logic                ch_req;
  logic                ch_ack;
  logic [EP_IDX_W-1:0] ch_ep_sel;

  // master: the arbiter; slave: endpoint register files plus the DMA channel
  modport master (
    input  ep_dma_req,
    input  ch_ack,
    output ep_dma_ack,
    output ch_req,
    output ch_ep_sel
  );

  modport slave (
    output ep_dma_req,
    output ch_ack,
    input  ep_dma_ack,
    input  ch_req,
    input  ch_ep_sel
  );

endinterface

// File: rtl/usbf_rr_pick.sv
// Combinational round-robin picker: first set request after 'last', wrapping modulo NUM_EP.
module usbf_rr_pick
  import usbf_dma_arb_pkg::*;
#(
  parameter int NUM_EP = 16
) (
  input  logic [NUM_EP-1:0]   req,
  input  logic [EP_IDX_W-1:0] last,
  output logic [EP_IDX_W-1:0] idx,
  output logic                valid
);

  logic [15:0]         req_ext;
  logic [EP_IDX_W:0]   cand;

  always_comb begin
    req_ext             = '0;
    req_ext[NUM_EP-1:0] = req;
    idx                 = '0;
    valid               = 1'b0;
    cand                = '0;
    // offset NUM_EP brings the search back to 'last' itself as the lowest priority
    for (int k = 1; k <= NUM_EP; k++) begin
      cand = {1'b0, last} + (EP_IDX_W + 1)'(k);
      if (cand >= (EP_IDX_W + 1)'(NUM_EP)) begin
        cand = cand - (EP_IDX_W + 1)'(NUM_EP);
      end
      if (!valid && req_ext[cand[EP_IDX_W-1:0]]) begin
        valid = 1'b1;
        idx   = cand[EP_IDX_W-1:0];
      end
    end
  end

endmodule

// File: rtl/usbf_dma_arb.sv
// Round-robin owner of the single DMA channel: grants one endpoint, forwards acks, bounds bursts.
module usbf_dma_arb
  import usbf_dma_arb_pkg::*;
#(
  parameter int NUM_EP    = 16,
  parameter int BURST_MAX = 16,
  parameter int HOLDOFF   = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              arb_en,
  input  logic [NUM_EP-1:0] ep_mask,
  input  logic [BEAT_W-1:0] burst_lim,
  output logic              busy,
  output logic              stray_ack,
  usbf_dma_arb_if.master    bus
);

  arb_state_e          state_reg;
  logic [EP_IDX_W-1:0] sel_reg;
  logic [EP_IDX_W-1:0] last_reg;
  logic [BEAT_W-1:0]   beat_reg;
  logic [BEAT_W-1:0]   lim_reg;
  logic [2:0]          hold_reg;
  logic                ch_req_reg;
  logic                busy_reg;
  logic                stray_reg;
  logic [NUM_EP-1:0]   ack_reg;

  logic [NUM_EP-1:0]   eligible;
  logic [NUM_EP-1:0]   sel_onehot;
  logic [EP_IDX_W-1:0] pick_idx;
  logic                pick_valid;
  logic                sel_req;
  logic                sel_mask;
  logic [BEAT_W-1:0]   beat_inc;
  logic                grant_end;

  assign eligible = bus.ep_dma_req & ep_mask & {NUM_EP{arb_en}};

  usbf_rr_pick #(
    .NUM_EP (NUM_EP)
  ) u_pick (
    .req   (eligible),
    .last  (last_reg),
    .idx   (pick_idx),
    .valid (pick_valid)
  );

  for (genvar gi = 0; gi < NUM_EP; gi++) begin : g_sel
    assign sel_onehot[gi] = (sel_reg == EP_IDX_W'(gi));
  end

  assign sel_req  = |(bus.ep_dma_req & sel_onehot);
  assign sel_mask = |(ep_mask & sel_onehot);
  assign beat_inc = beat_reg + BEAT_W'(1);

  // A request drop only ends the grant when no ack is in flight that cycle.
  assign grant_end = (bus.ch_ack && (beat_inc == lim_reg))
                   || (!sel_req && !bus.ch_ack)
                   || !sel_mask
                   || !arb_en;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= IDLE;
      sel_reg    <= '0;
      last_reg   <= EP_IDX_W'(NUM_EP - 1);
      beat_reg   <= '0;
      lim_reg    <= '0;
      hold_reg   <= '0;
      ch_req_reg <= 1'b0;
      busy_reg   <= 1'b0;
      stray_reg  <= 1'b0;
      ack_reg    <= '0;
    end else begin
      ack_reg   <= '0;
      stray_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          stray_reg <= bus.ch_ack;
          if (pick_valid) begin
            state_reg  <= ACTIVE;
            sel_reg    <= pick_idx;
            last_reg   <= pick_idx;
            beat_reg   <= '0;
            lim_reg    <= (burst_lim == '0) ? BEAT_W'(BURST_MAX) : burst_lim;
            ch_req_reg <= 1'b1;
            busy_reg   <= 1'b1;
          end
        end
        ACTIVE: begin
          if (bus.ch_ack) begin
            ack_reg  <= sel_onehot;
            beat_reg <= beat_inc;
          end
          if (grant_end) begin
            // the HOLDOFF parameter shadows the imported state name here
            state_reg  <= usbf_dma_arb_pkg::HOLDOFF;
            ch_req_reg <= 1'b0;
            hold_reg   <= '0;
          end
        end
        usbf_dma_arb_pkg::HOLDOFF: begin
          stray_reg <= bus.ch_ack;
          if (hold_reg == 3'(HOLDOFF - 1)) begin
            state_reg <= IDLE;
            busy_reg  <= 1'b0;
          end else begin
            hold_reg <= hold_reg + 3'd1;
          end
        end
        default: begin
          state_reg  <= IDLE;
          ch_req_reg <= 1'b0;
          busy_reg   <= 1'b0;
        end
      endcase
    end
  end

  assign bus.ch_req     = ch_req_reg;
  assign bus.ch_ep_sel  = sel_reg;
  assign bus.ep_dma_ack = ack_reg;
  assign busy           = busy_reg;
  assign stray_ack      = stray_reg;

endmodule

// File: tb/tb_usbf_dma_arb.sv
// Randomized bench for usbf_dma_arb: a grant-level model queues expected events, a monitor checks them.
module tb_usbf_dma_arb;

  localparam int NUM_EP    = 16;
  localparam int BURST_MAX = 16;
  localparam int HOLDOFF   = 2;

  localparam int K_ACK   = 0;
  localparam int K_GRANT = 1;
  localparam int K_DROP  = 2;
  localparam int K_STRAY = 3;
  localparam int K_BUSY  = 4;

  typedef struct {
    int cyc;
    int kind;
    int val;
  } ev_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        arb_en = 1'b0;
  logic [15:0] ep_mask = '0;
  logic [4:0]  burst_lim = '0;
  logic        busy;
  logic        stray_ack;

  usbf_dma_arb_if #(.NUM_EP(NUM_EP)) bus_if ();

  usbf_dma_arb #(
    .NUM_EP    (NUM_EP),
    .BURST_MAX (BURST_MAX),
    .HOLDOFF   (HOLDOFF)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .arb_en    (arb_en),
    .ep_mask   (ep_mask),
    .burst_lim (burst_lim),
    .busy      (busy),
    .stray_ack (stray_ack),
    .bus       (bus_if)
  );

  always #5 clk = ~clk;

  ev_t exp_q[$];
  int  total = 0;
  int  bad   = 0;
  int  cyc   = 0;

  task automatic chk(input string name, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, got, want);
    end
  endtask

  // Reference model: grant ownership, acks remaining and quiet time, evaluated per clock.
  initial begin : model
    int          gep, done, lim_e, quiet, last, e;
    bit          a, mb, prev_mb;
    logic [15:0] rq, elig;
    gep = -1; done = 0; lim_e = 0; quiet = 0; last = NUM_EP - 1; prev_mb = 1'b0;
    forever begin
      @(posedge clk);
      cyc++;
      if (!rst_n) begin
        gep = -1; quiet = 0; last = NUM_EP - 1; prev_mb = 1'b0;
        continue;
      end
      a  = bus_if.ch_ack;
      rq = bus_if.ep_dma_req;
      if (gep >= 0) begin
        if (a) begin
          exp_q.push_back('{cyc, K_ACK, gep});
          done++;
        end
        if ((a && done == lim_e) || (!rq[gep] && !a) || !ep_mask[gep] || !arb_en) begin
          exp_q.push_back('{cyc, K_DROP, 0});
          gep   = -1;
          quiet = HOLDOFF;
        end
      end else begin
        if (a) exp_q.push_back('{cyc, K_STRAY, 0});
        if (quiet > 0) begin
          quiet--;
        end else begin
          elig = rq & ep_mask & {16{arb_en}};
          for (int k = 1; k <= NUM_EP; k++) begin
            e = (last + k) % NUM_EP;
            if (elig[e]) begin
              gep = e;
              break;
            end
          end
          if (gep >= 0) begin
            last  = gep;
            done  = 0;
            lim_e = (burst_lim == 0) ? BURST_MAX : int'(burst_lim);
            exp_q.push_back('{cyc, K_GRANT, gep});
          end
        end
      end
      mb = (gep >= 0) || (quiet > 0);
      if (mb != prev_mb) exp_q.push_back('{cyc, K_BUSY, 0});
      prev_mb = mb;
    end
  end

  // Monitor: on each DUT output event, compare against what the model queued for this cycle.
  initial begin : monitor
    ev_t         ev;
    int          e_ack, e_grant;
    bit          e_drop, e_stray, e_busy, pr, pb, rise, fall, chg;
    logic [15:0] want;
    pr = 1'b0; pb = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        pr = 1'b0; pb = 1'b0;
        continue;
      end
      e_ack = -1; e_grant = -1; e_drop = 1'b0; e_stray = 1'b0; e_busy = 1'b0;
      while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
        ev = exp_q.pop_front();
        case (ev.kind)
          K_ACK:   e_ack   = ev.val;
          K_GRANT: e_grant = ev.val;
          K_DROP:  e_drop  = 1'b1;
          K_STRAY: e_stray = 1'b1;
          default: e_busy  = 1'b1;
        endcase
      end
      want = (e_ack >= 0) ? (16'd1 << e_ack) : 16'd0;
      if (bus_if.ep_dma_ack != 0 || e_ack >= 0) chk("ep_dma_ack", int'(bus_if.ep_dma_ack), int'(want));
      rise = bus_if.ch_req && !pr;
      fall = !bus_if.ch_req && pr;
      chg  = (busy != pb);
      if (rise || e_grant >= 0) begin
        chk("grant_time", int'(rise), int'(e_grant >= 0));
        if (rise && e_grant >= 0) chk("grant_ep", int'(bus_if.ch_ep_sel), e_grant);
      end
      if (fall || e_drop) chk("grant_end", int'(fall), int'(e_drop));
      if (stray_ack || e_stray) chk("stray_ack", int'(stray_ack), int'(e_stray));
      if (chg || e_busy) chk("busy_change", int'(chg), int'(e_busy));
      pr = bus_if.ch_req;
      pb = busy;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic follow(input int n);
    repeat (n) begin
      tick();
      bus_if.ch_ack = bus_if.ch_req;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      tick();
      bus_if.ch_ack = 1'b0;
    end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_ch_req"}, int'(bus_if.ch_req), 0);
    chk({tag, "_ack"}, int'(bus_if.ep_dma_ack), 0);
    chk({tag, "_sel"}, int'(bus_if.ch_ep_sel), 0);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_stray"}, int'(stray_ack), 0);
  endtask

  initial begin : stim
    int cnt;
    bus_if.ep_dma_req = '0;
    bus_if.ch_ack     = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_zero("reset");

    // single requester, burst of 4, channel acks every active cycle
    ep_mask = '1; arb_en = 1'b1; burst_lim = 5'd4; bus_if.ep_dma_req = 16'h0001;
    @(negedge clk); #1 rst_n = 1'b1;
    follow(30);

    // four requesters, one ack per grant: rotation 0,5,10,15
    bus_if.ep_dma_req = 16'h8421; burst_lim = 5'd1;
    follow(40);

    // EP3 withdraws after two acks
    bus_if.ep_dma_req = 16'h0008; burst_lim = 5'd8; cnt = 0;
    for (int i = 0; i < 60 && cnt < 2; i++) begin
      tick();
      if (bus_if.ep_dma_ack[3]) cnt++;
      bus_if.ch_ack = bus_if.ch_req && (cnt < 2);
      if (cnt == 2) bus_if.ep_dma_req = 16'h0000;
    end
    chk("ep3_two_acks", cnt, 2);
    idle(10);

    // arb_en falls in the same cycle as an ack
    bus_if.ep_dma_req = 16'h0010;
    for (int i = 0; i < 20 && !bus_if.ch_req; i++) tick();
    chk("ep4_granted", int'(bus_if.ch_req), 1);
    bus_if.ch_ack = 1'b1;
    tick();
    bus_if.ch_ack = 1'b1; arb_en = 1'b0;
    idle(10);
    bus_if.ep_dma_req = 16'h0000; arb_en = 1'b1;

    // stray ack while idle
    idle(6);
    bus_if.ch_ack = 1'b1;
    idle(4);

    // burst_lim 0 selects the full default burst
    bus_if.ep_dma_req = 16'h0002; burst_lim = 5'd0;
    follow(45);
    bus_if.ep_dma_req = 16'h0000;
    idle(8);

    // reset in the middle of an EP7 burst, then EP0 must win over EP7
    bus_if.ep_dma_req = 16'h0080; burst_lim = 5'd8; cnt = 0;
    for (int i = 0; i < 60 && cnt < 3; i++) begin
      tick();
      if (bus_if.ep_dma_ack[7]) cnt++;
      bus_if.ch_ack = bus_if.ch_req;
    end
    chk("ep7_three_acks", cnt, 3);
    @(negedge clk); #1 rst_n = 1'b0;
    #1 check_zero("async_rst");
    bus_if.ch_ack = 1'b0; bus_if.ep_dma_req = 16'h0081;
    repeat (2) @(posedge clk);
    @(negedge clk); #1 rst_n = 1'b1;
    follow(30);

    // randomized traffic, including strays and mask/enable churn
    repeat (1500) begin
      tick();
      if ($urandom_range(7) == 0) bus_if.ep_dma_req = 16'($urandom) & 16'($urandom);
      ep_mask       = ($urandom_range(15) == 0) ? 16'($urandom) : 16'hffff;
      arb_en        = ($urandom_range(31) != 0);
      if ($urandom_range(15) == 0) burst_lim = 5'($urandom_range(7));
      bus_if.ch_ack = ($urandom_range(1) == 1);
    end

    bus_if.ep_dma_req = 16'h0000;
    idle(12);
    chk("queue_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
